// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and defaults for the SRAM request interface
//
// Purpose: common state/owner enums, bus width defaults and the request record
// used by the SRAM port arbiter and by the audio effect clients.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } sram_state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } sram_owner_t;

  typedef struct packed {
    logic                   we_n;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - req/ack client interface of the SRAM port arbiter
//
// Purpose: one client's word request channel.
// Signals: req (level, held until ack), we_n (0 = write), addr, wdata,
//          ack (one-cycle completion pulse), rdata (valid with ack on reads).
// Modports: master = client side, slave = arbiter side.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we_n, addr, wdata, input ack, rdata);
  modport slave  (input req, we_n, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - two-request round-robin grant
//
// Purpose: picks client A or B; on a tie the client not granted last wins.
// Ports: i_clk, i_rst_n (sync, active-low), i_en (grant only when set),
//        i_req [0]=A [1]=B, o_grant one-hot [0]=A [1]=B (combinational).
module sram_rr_arbiter
  import sram_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  sram_owner_t last_grant;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = (last_grant == OWN_B) ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  // Reset to B so that A wins the very first tie.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_grant <= OWN_B;
    end else if (o_grant[0]) begin
      last_grant <= OWN_A;
    end else if (o_grant[1]) begin
      last_grant <= OWN_B;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-client arbiter driving one asynchronous 1Mx16 SRAM
//
// Purpose: serves word reads/writes from client A (recorder/player) and
// client B (loop effect) with SETUP / ACCESS(1+WAIT_CYCLES) / DONE phasing.
// Ports: i_clk, i_rst_n (sync, active-low), client_a / client_b (req/ack
//        channels), o_SRAM_ADDR, io_SRAM_DQ, o_SRAM_CE_N/OE_N/WE_N/LB_N/UB_N.
// All outputs are registered; strobes are computed from the next state so
// they line up with the state they belong to.
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  sram_port_arbiter_if.slave  client_a,
  sram_port_arbiter_if.slave  client_b,
  output logic [ADDR_W-1:0]   o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0]   io_SRAM_DQ,
  output logic                o_SRAM_CE_N,
  output logic                o_SRAM_OE_N,
  output logic                o_SRAM_WE_N,
  output logic                o_SRAM_LB_N,
  output logic                o_SRAM_UB_N
);

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  sram_state_t       state, state_nxt;
  sram_owner_t       own_q, own_nxt;
  logic              we_n_q, we_n_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [2:0]        wait_cnt;
  logic [1:0]        grant;
  logic              dq_oe_q;
  logic [DATA_W-1:0] dq_out_q;
  logic              a_ack_q, b_ack_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              last_access;

  sram_rr_arbiter u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (state == ST_IDLE),
    .i_req   ({client_b.req, client_a.req}),
    .o_grant (grant)
  );

  assign last_access = (state == ST_ACCESS) && (wait_cnt == 3'd0);

  // Next state plus the request that will own the bus: in IDLE this is the
  // freshly granted client, otherwise the latched copy (inputs are ignored).
  always_comb begin
    state_nxt = state;
    own_nxt   = own_q;
    we_n_nxt  = we_n_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    case (state)
      ST_IDLE: begin
        if (grant[0]) begin
          own_nxt   = OWN_A;
          we_n_nxt  = client_a.we_n;
          addr_nxt  = client_a.addr;
          wdata_nxt = client_a.wdata;
          state_nxt = ST_SETUP;
        end else if (grant[1]) begin
          own_nxt   = OWN_B;
          we_n_nxt  = client_b.we_n;
          addr_nxt  = client_b.addr;
          wdata_nxt = client_b.wdata;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (wait_cnt == 3'd0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      own_q       <= OWN_A;
      we_n_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_cnt    <= 3'd0;
      o_SRAM_ADDR <= '0;
      o_SRAM_CE_N <= 1'b1;
      o_SRAM_OE_N <= 1'b1;
      o_SRAM_WE_N <= 1'b1;
      o_SRAM_LB_N <= 1'b1;
      o_SRAM_UB_N <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state   <= state_nxt;
      own_q   <= own_nxt;
      we_n_q  <= we_n_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;

      // Loaded while in SETUP so the first ACCESS cycle sees the full count.
      if (state == ST_SETUP) begin
        wait_cnt <= WAIT_LOAD;
      end else if ((state == ST_ACCESS) && (wait_cnt != 3'd0)) begin
        wait_cnt <= wait_cnt - 3'd1;
      end

      if (state_nxt != ST_IDLE) begin
        o_SRAM_ADDR <= addr_nxt;
      end
      o_SRAM_CE_N <= (state_nxt == ST_IDLE);
      o_SRAM_LB_N <= (state_nxt == ST_IDLE);
      o_SRAM_UB_N <= (state_nxt == ST_IDLE);
      o_SRAM_OE_N <= !((state_nxt == ST_ACCESS) && we_n_nxt);
      o_SRAM_WE_N <= !((state_nxt == ST_ACCESS) && !we_n_nxt);

      // Writes drive DQ from SETUP through DONE (setup and hold around WE_N);
      // reads and IDLE never drive, so there is no turnaround overlap.
      dq_oe_q  <= (state_nxt != ST_IDLE) && !we_n_nxt;
      dq_out_q <= wdata_nxt;

      a_ack_q <= (state_nxt == ST_DONE) && (own_nxt == OWN_A);
      b_ack_q <= (state_nxt == ST_DONE) && (own_nxt == OWN_B);

      if (last_access && we_n_q) begin
        if (own_q == OWN_A) begin
          a_rdata_q <= io_SRAM_DQ;
        end else begin
          b_rdata_q <= io_SRAM_DQ;
        end
      end
    end
  end

  assign io_SRAM_DQ     = dq_oe_q ? dq_out_q : 'z;
  assign client_a.ack   = a_ack_q;
  assign client_b.ack   = b_ack_q;
  assign client_a.rdata = a_rdata_q;
  assign client_b.rdata = b_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
  import sram_pkg::*;

  localparam int AW = 20;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int failures = 0;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();
  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a2_if ();
  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b2_if ();

  wire  [DW-1:0] dq, dq2;
  logic [AW-1:0] sa, sa2;
  logic ce_n, oe_n, we_n, lb_n, ub_n;
  logic ce2_n, oe2_n, we2_n, lb2_n, ub2_n;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .client_a(a_if), .client_b(b_if),
    .o_SRAM_ADDR(sa), .io_SRAM_DQ(dq), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
    .o_SRAM_WE_N(we_n), .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .client_a(a2_if), .client_b(b2_if),
    .o_SRAM_ADDR(sa2), .io_SRAM_DQ(dq2), .o_SRAM_CE_N(ce2_n), .o_SRAM_OE_N(oe2_n),
    .o_SRAM_WE_N(we2_n), .o_SRAM_LB_N(lb2_n), .o_SRAM_UB_N(ub2_n)
  );

  // Asynchronous SRAM model (low 12 address bits) for the WAIT_CYCLES=0 instance.
  logic [15:0] mem [0:4095];
  assign dq = (!ce_n && !oe_n) ? mem[sa[11:0]] : 'z;
  always @(posedge clk) if (!ce_n && !we_n) mem[sa[11:0]] <= dq;

  // The WAIT_CYCLES=2 model returns a value that changes every OE cycle,
  // exposing which strobe cycle the data was taken from.
  logic [3:0] oe2_run = 4'd0;
  always @(posedge clk) oe2_run <= !oe2_n ? oe2_run + 4'd1 : 4'd0;
  assign dq2 = (!ce2_n && !oe2_n) ? {12'hA50, oe2_run} : 'z;

  // Reference model: memory contents, expected held rdata, last served client.
  logic [15:0] ref_mem [0:4095];
  logic [15:0] exp_a_rd, exp_b_rd;
  bit          last_b;

  task automatic test_reset();
    logic [26:0] obs;
    @(negedge clk);
    rst_n = 1'b0;
    a_if.req = 1'b1; a_if.we_n = 1'b0; a_if.addr = 20'h00123; a_if.wdata = 16'h7777;
    repeat (3) @(negedge clk);
    obs = {sa, ce_n, oe_n, we_n, lb_n, ub_n, a_if.ack, b_if.ack};
    checks++;
    if (obs !== {20'h0, 5'b11111, 2'b00}) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, {20'h0, 5'b11111, 2'b00});
    end
    checks++;
    if ({a_if.rdata, b_if.rdata} !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0", {a_if.rdata, b_if.rdata});
    end
    checks++;
    if ({ce2_n, oe2_n, we2_n, a2_if.ack} !== 4'b1110) begin
      failures++; $display("FAIL reset_dut2 got=%b exp=1110", {ce2_n, oe2_n, we2_n, a2_if.ack});
    end
    a_if.req = 1'b0;
    rst_n = 1'b1;
    exp_a_rd = 16'h0; exp_b_rd = 16'h0; last_b = 1'b1;
  endtask

  task automatic single_access(input bit use_b, input bit wr, input logic [19:0] addr,
                               input logic [15:0] wdata, input string name);
    logic [26:0] obs, expv;
    int oe_lo;
    @(negedge clk);
    if (use_b) begin
      b_if.req = 1'b1; b_if.we_n = !wr; b_if.addr = addr; b_if.wdata = wdata;
    end else begin
      a_if.req = 1'b1; a_if.we_n = !wr; a_if.addr = addr; a_if.wdata = wdata;
    end
    oe_lo = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (!oe_n) oe_lo++;
      obs  = {sa, ce_n, oe_n, we_n, lb_n, ub_n, a_if.ack, b_if.ack};
      expv = {addr, 1'b0, !(c == 2 && !wr), !(c == 2 && wr), 2'b00,
              (c == 3 && !use_b), (c == 3 && use_b)};
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL %s_cycle%0d got=%h exp=%h", name, c, obs, expv);
      end
      if (wr) begin
        checks++;
        if (dq !== wdata) begin
          failures++; $display("FAIL %s_dq_cycle%0d got=%h exp=%h", name, c, dq, wdata);
        end
      end
    end
    if (wr) ref_mem[addr[11:0]] = wdata;
    else if (use_b) exp_b_rd = ref_mem[addr[11:0]];
    else exp_a_rd = ref_mem[addr[11:0]];
    last_b = use_b;
    checks++;
    if ({a_if.rdata, b_if.rdata} !== {exp_a_rd, exp_b_rd}) begin
      failures++; $display("FAIL %s_rdata got=%h exp=%h", name, {a_if.rdata, b_if.rdata}, {exp_a_rd, exp_b_rd});
    end
    if (!wr) begin
      checks++;
      if (oe_lo != 1) begin
        failures++; $display("FAIL %s_oe_cycles got=%0d exp=1", name, oe_lo);
      end
    end
    a_if.req = 1'b0; b_if.req = 1'b0;
    @(negedge clk);
    checks++;
    if ({ce_n, a_if.ack, b_if.ack} !== 3'b100) begin
      failures++; $display("FAIL %s_idle got=%b exp=100", name, {ce_n, a_if.ack, b_if.ack});
    end
  endtask

  task automatic test_round_robin();
    int n, cyc, last_cyc;
    bit exp_b;
    @(negedge clk);
    a_if.req = 1'b1; a_if.we_n = 1'b0; a_if.addr = {8'h0, 12'($urandom)}; a_if.wdata = 16'($urandom);
    b_if.req = 1'b1; b_if.we_n = 1'b1; b_if.addr = {8'h0, 12'($urandom)};
    n = 0; cyc = 0; last_cyc = 0;
    while (n < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (a_if.ack && b_if.ack) begin
        failures++; $display("FAIL rr_ack_overlap got=11 exp=not_both cycle=%0d", cyc);
      end
      if (!oe_n) begin
        checks++;
        if (!we_n) begin
          failures++; $display("FAIL rr_oe_we_both_low got=00 exp=not_both cycle=%0d", cyc);
        end
      end
      if (a_if.ack || b_if.ack) begin
        exp_b = !last_b;
        checks++;
        if (b_if.ack !== exp_b) begin
          failures++; $display("FAIL rr_grant%0d got_b=%b exp_b=%b", n, b_if.ack, exp_b);
        end
        checks++;
        if ((cyc - last_cyc) != ((n == 0) ? 3 : 4)) begin
          failures++; $display("FAIL rr_spacing%0d got=%0d exp=%0d", n, cyc - last_cyc, (n == 0) ? 3 : 4);
        end
        last_cyc = cyc;
        if (a_if.ack) begin
          ref_mem[a_if.addr[11:0]] = a_if.wdata;
          last_b = 1'b0;
          a_if.addr = {8'h0, 12'($urandom)}; a_if.wdata = 16'($urandom);
        end else begin
          exp_b_rd = ref_mem[b_if.addr[11:0]];
          last_b = 1'b1;
          checks++;
          if (b_if.rdata !== exp_b_rd) begin
            failures++; $display("FAIL rr_read%0d got=%h exp=%h", n, b_if.rdata, exp_b_rd);
          end
          b_if.addr = {8'h0, 12'($urandom)};
        end
        n++;
      end
    end
    checks++;
    if (n != 6) begin
      failures++; $display("FAIL rr_timeout got=%0d exp=6 acks", n);
    end
    a_if.req = 1'b0; b_if.req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int pat, cyc;
    bit exp_b, wa, wb, got;
    logic [19:0] aa, ab;
    logic [15:0] da, db;
    for (int it = 0; it < 16; it++) begin
      @(negedge clk);
      pat = $urandom_range(1, 3);
      wa = 1'($urandom); wb = 1'($urandom);
      aa = {8'h0, 12'($urandom)}; ab = {8'h0, 12'($urandom)};
      da = 16'($urandom); db = 16'($urandom);
      a_if.req = pat[0]; a_if.we_n = !wa; a_if.addr = aa; a_if.wdata = da;
      b_if.req = pat[1]; b_if.we_n = !wb; b_if.addr = ab; b_if.wdata = db;
      exp_b = (pat == 3) ? !last_b : (pat == 2);
      cyc = 0; got = 1'b0;
      while (!got && cyc < 8) begin
        @(negedge clk);
        cyc++;
        got = a_if.ack || b_if.ack;
      end
      checks++;
      if (!got || cyc != 3 || b_if.ack !== exp_b || a_if.ack !== !exp_b) begin
        failures++;
        $display("FAIL rand%0d_grant got_cyc=%0d got_ab=%b%b exp_cyc=3 exp_b=%b", it, cyc, a_if.ack, b_if.ack, exp_b);
      end
      if (exp_b) begin
        if (wb) ref_mem[ab[11:0]] = db; else exp_b_rd = ref_mem[ab[11:0]];
      end else begin
        if (wa) ref_mem[aa[11:0]] = da; else exp_a_rd = ref_mem[aa[11:0]];
      end
      last_b = exp_b;
      checks++;
      if ({a_if.rdata, b_if.rdata} !== {exp_a_rd, exp_b_rd}) begin
        failures++; $display("FAIL rand%0d_rdata got=%h exp=%h", it, {a_if.rdata, b_if.rdata}, {exp_a_rd, exp_b_rd});
      end
      a_if.req = 1'b0; b_if.req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_access();
    int cyc;
    bit got, a_seen;
    @(negedge clk);
    b_if.req = 1'b1; b_if.we_n = 1'b0; b_if.addr = 20'h00300; b_if.wdata = 16'h5A5A;
    repeat (2) @(negedge clk);
    checks++;
    if (we_n !== 1'b0) begin
      failures++; $display("FAIL rstmid_in_access got_we_n=%b exp=0", we_n);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ce_n, oe_n, we_n, lb_n, ub_n, a_if.ack, b_if.ack} !== 7'b1111100) begin
      failures++; $display("FAIL rstmid_strobes got=%b exp=1111100", {ce_n, oe_n, we_n, lb_n, ub_n, a_if.ack, b_if.ack});
    end
    rst_n = 1'b1;
    exp_a_rd = 16'h0; exp_b_rd = 16'h0;
    cyc = 0; got = 1'b0; a_seen = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      got = b_if.ack;
      a_seen = a_seen || a_if.ack;
    end
    checks++;
    if (!got || cyc != 3 || a_seen) begin
      failures++; $display("FAIL rstmid_retry got_cyc=%0d got_ack=%b a_ack=%b exp_cyc=3", cyc, got, a_seen);
    end
    ref_mem[12'h300] = 16'h5A5A;
    last_b = 1'b1;
    b_if.req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem[12'h300] !== 16'h5A5A) begin
      failures++; $display("FAIL rstmid_mem got=%h exp=5a5a", mem[12'h300]);
    end
  endtask

  task automatic test_addr_change();
    logic [15:0] old20;
    old20 = ref_mem[12'h020];
    @(negedge clk);
    b_if.req = 1'b1; b_if.we_n = 1'b0; b_if.addr = 20'h00010; b_if.wdata = 16'hBEEF;
    repeat (2) @(negedge clk);
    b_if.addr = 20'h00020; b_if.wdata = 16'h0BAD;
    @(negedge clk);
    checks++;
    if ({sa, b_if.ack, dq} !== {20'h00010, 1'b1, 16'hBEEF}) begin
      failures++; $display("FAIL addrchg_done got=%h exp=%h", {sa, b_if.ack, dq}, {20'h00010, 1'b1, 16'hBEEF});
    end
    b_if.req = 1'b0;
    ref_mem[12'h010] = 16'hBEEF;
    last_b = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem[12'h010], mem[12'h020]} !== {16'hBEEF, old20}) begin
      failures++; $display("FAIL addrchg_mem got=%h exp=%h", {mem[12'h010], mem[12'h020]}, {16'hBEEF, old20});
    end
  endtask

  task automatic test_wait_cycles();
    logic [7:0] oe_mask;
    int ack_cyc;
    @(negedge clk);
    a2_if.req = 1'b1; a2_if.we_n = 1'b1; a2_if.addr = 20'h00055; a2_if.wdata = 16'h0;
    oe_mask = 8'h0; ack_cyc = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (!oe2_n) oe_mask[c] = 1'b1;
      if (a2_if.ack) begin
        if (ack_cyc == 0) ack_cyc = c;
        a2_if.req = 1'b0;
        checks++;
        if (a2_if.rdata !== 16'hA502) begin
          failures++; $display("FAIL wait2_rdata got=%h exp=a502", a2_if.rdata);
        end
      end
    end
    a2_if.req = 1'b0;
    checks++;
    if (oe_mask !== 8'b0001_1100) begin
      failures++; $display("FAIL wait2_oe_cycles got=%b exp=00011100", oe_mask);
    end
    checks++;
    if (ack_cyc != 5) begin
      failures++; $display("FAIL wait2_ack_cycle got=%0d exp=5", ack_cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    rst_n = 1'b0;
    a_if.req = 1'b0; a_if.we_n = 1'b1; a_if.addr = '0; a_if.wdata = '0;
    b_if.req = 1'b0; b_if.we_n = 1'b1; b_if.addr = '0; b_if.wdata = '0;
    a2_if.req = 1'b0; a2_if.we_n = 1'b1; a2_if.addr = '0; a2_if.wdata = '0;
    b2_if.req = 1'b0; b2_if.we_n = 1'b1; b2_if.addr = '0; b2_if.wdata = '0;
    exp_a_rd = 16'h0; exp_b_rd = 16'h0; last_b = 1'b1;

    test_reset();
    single_access(1'b0, 1'b1, 20'h07D00, 16'h1234, "a_write");
    single_access(1'b1, 1'b0, 20'h07D00, 16'h0000, "b_read");
    test_round_robin();
    test_random();
    test_reset_mid_access();
    test_addr_change();
    test_wait_cycles();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
